// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Dividend on g_input, divisor on e_input; quotient on o, remainder on rem after N RUN cycles.
module div_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] g_input,
    input  logic [N-1:0] e_input,
    output logic [N-1:0] o,
    output logic [N-1:0] rem,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [0:0]    IDLE = 1'b0;
    localparam logic [0:0]    RUN  = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [0:0]    state;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    // The partial remainder only ever holds a value below 2^N after a
    // restoring step (T[N]=0 whenever T is kept), so its top bit is always
    // zero and is not stored; the N+1-bit width lives in p_shift/trial.
    logic [N-1:0]  p_reg;
    logic [CW-1:0] cnt;

    logic [N:0]    p_shift;
    logic [N:0]    trial;
    logic [N-1:0]  q_next;
    logic [N-1:0]  p_next;

    // NOTE: every always_comb output is assigned on every path, so no latches.
    always_comb begin
        p_shift = {p_reg, q_reg[N-1]};
        trial   = p_shift - {1'b0, d_reg};
        q_next  = {q_reg[N-2:0], ~trial[N]};
        p_next  = trial[N] ? p_shift[N-1:0] : trial[N-1:0];
    end

    assign busy = (state == RUN);

    // NOTE: sequential state uses non-blocking assignments only; the whole
    // datapath is reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q_reg <= '0;
            d_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
            o     <= '0;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= g_input;
                        d_reg <= e_input;
                        p_reg <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    p_reg <= p_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        o     <= q_next;
                        rem   <= p_next;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential unsigned restoring divider; the inverse operation of the combinational multiplier in the arithmetic circuit library.
- Dividend arrives on g_input, divisor on e_input; produces quotient and remainder one bit per clock.
- Start/busy/done handshake so it can sit inside multi-cycle garbled-circuit datapaths.
- Area is kept to one N+1-bit subtractor plus shift registers.

Parameters:
- N, 32, operand width in bits (dividend, divisor, quotient, remainder); N >= 2.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset (rst=0 resets immediately; release synchronous to clk is the integrator's responsibility)
- start  input  1  request; accepted only on a rising edge where busy=0
- g_input  input  N  dividend, sampled on the accepting edge only
- e_input  input  N  divisor, sampled on the accepting edge only
- o  output  N  quotient, registered
- rem  output  N  remainder, registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: o/rem valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, o=0, rem=0, busy=0, done=0, iteration counter=0, internal dividend/divisor/partial-remainder registers=0.
- Reset mid-operation aborts the operation with no done pulse. After release, the block is IDLE.
- FSM has two states, IDLE and RUN.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture g_input into the quotient/shift register and e_input into the divisor register; clear the N+1-bit partial remainder P and the counter; go to RUN; busy=1 from this edge.
- RUN: each edge performs one restoring step:
  - P' = {P[N-1:0], Q[N-1]}; Q shifted left by 1.
  - T = P' - {1'b0, D}, computed at N+1 bits.
  - If T[N]=0: P=T and Q[0]=1. Else: P=P' and Q[0]=0.
  - Counter increments.
  - On the N-th RUN edge: o=final Q, rem=final P[N-1:0], done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency and throughput:
  - Start accepted on edge k; done=1 and results valid after edge k+N.
  - Throughput is one result per N+1 cycles when back-to-back.
  - In the cycle where done=1 the block is IDLE, so start=1 in that cycle is accepted on the next edge.
- Divide by zero (divisor=0): no special-case logic. The algorithm naturally yields o = all ones, rem = dividend, with normal latency N. This is the required result.
- Operand holding:
  - start while busy=1 is ignored: no restart, no effect on the in-flight operation.
  - g_input/e_input changes during RUN have no effect.
- o/rem hold their last values until the next completion. They are not cleared on start.
- done is never high while busy is high.
- Unsigned arithmetic only. Invariant on completion: g_input = o*e_input + rem, with rem < e_input when e_input != 0.

Test Plan:
- N=8, reset then start with g_input=100, e_input=7 → busy high for 8 cycles; done pulse after edge k+8; o=14, rem=2; done low the next cycle; o/rem held.
- N=8, g_input=0xA5, e_input=0 → o=0xFF, rem=0xA5 with latency 8. Also g_input=0xFF, e_input=1 → o=0xFF, rem=0. Also g_input=5, e_input=9 → o=0, rem=5.
- N=8, start 200/3, then assert start with 50/5 at cycles k+2 and k+5 → only one done; o=66, rem=2; second request ignored. Then start held high in the done cycle → new operation accepted with no idle gap beyond 1 cycle.
- N=8, start 77/4, assert rst=0 asynchronously mid-cycle at k+4 → o=0, rem=0, busy=0 immediately with no done. After release, 77/4 completes normally with o=19, rem=1.
- N=32, 10,000 random operand pairs including divisor=0 and divisor>dividend → every done matches the reference model (quotient, remainder, all-ones on divide-by-zero); latency exactly 32 every time.
